// File: rtl/uart_hex_tx_pkg.sv
// Shared definitions for the hex-print UART path: FSM encoding and ASCII constants.
package uart_hex_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DIGIT = 2'd1,
      CR    = 2'd2,
      LF    = 2'd3
   } state_t;

   localparam logic [7:0] ASCII_ZERO    = 8'h30;
   localparam logic [7:0] ASCII_UPPER_A = 8'h41;
   localparam logic [7:0] ASCII_CR      = 8'h0D;
   localparam logic [7:0] ASCII_LF      = 8'h0A;
   localparam logic [7:0] ASCII_NUL     = 8'h00;
   localparam logic [3:0] NIBBLE_TEN    = 4'd10;

endpackage

// File: rtl/uart_hex_tx_nibble_to_ascii.sv
// Combinational nibble to uppercase hex ASCII character converter.
module nibble_to_ascii
   import uart_hex_tx_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   // Map 0-9 onto '0'..'9' and 10-15 onto 'A'..'F'.
   always_comb begin
      ascii = ASCII_NUL;
      if (nibble < NIBBLE_TEN) begin
         ascii = ASCII_ZERO + {4'h0, nibble};
      end else begin
         ascii = ASCII_UPPER_A + {4'h0, nibble - NIBBLE_TEN};
      end
   end

endmodule

// File: rtl/uart_hex_tx.sv
// Prints a binary value as fixed-width uppercase hex (optionally CR LF
// terminated) one character at a time into a valid/ready tx FIFO port.
module uart_hex_tx
   import uart_hex_tx_pkg::*;
#(
   parameter int value_width = 32,
   parameter bit append_crlf = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [value_width-1:0] in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [7:0]             wdata,
   output logic                   wvalid,
   input  logic                   wready,
   output logic                   busy
);

   localparam int NDIG = value_width / 4;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(NDIG - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   state_t                 state_q, state_d;
   logic [value_width-1:0] value_q, value_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   in_ready_q, in_ready_d;
   logic                   wvalid_q, wvalid_d;
   logic [7:0]             wdata_q, wdata_d;
   logic                   busy_q, busy_d;
   logic [3:0]             nibble_s;
   logic [7:0]             ascii_s;
   logic                   xfer_s;

   assign xfer_s = wvalid_q & wready;

   // Next state, latched value and digit counter; advance only on a handshake.
   always_comb begin
      state_d = state_q;
      value_d = value_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = DIGIT;
               value_d = in_data;
               cnt_d   = CNT_LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         DIGIT: begin
            if (xfer_s) begin
               value_d = value_q << 3'd4;
               if (cnt_q == CNT_ZERO) begin
                  state_d = append_crlf ? CR : IDLE;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end else begin
               state_d = DIGIT;
            end
         end
         CR: begin
            if (xfer_s) begin
               state_d = LF;
            end else begin
               state_d = CR;
            end
         end
         LF: begin
            if (xfer_s) begin
               state_d = IDLE;
            end else begin
               state_d = LF;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The next character to show is always the top nibble of the next value.
   assign nibble_s = value_d[value_width-1 -: 4];

   nibble_to_ascii u_nibble_to_ascii (
      .nibble (nibble_s),
      .ascii  (ascii_s)
   );

   // Output values for the coming cycle, decoded from the next state so they can be registered.
   always_comb begin
      in_ready_d = 1'b1;
      wvalid_d   = 1'b0;
      busy_d     = 1'b0;
      wdata_d    = ASCII_NUL;
      case (state_d)
         IDLE: begin
            in_ready_d = 1'b1;
         end
         DIGIT: begin
            in_ready_d = 1'b0;
            wvalid_d   = 1'b1;
            busy_d     = 1'b1;
            wdata_d    = ascii_s;
         end
         CR: begin
            in_ready_d = 1'b0;
            wvalid_d   = 1'b1;
            busy_d     = 1'b1;
            wdata_d    = ASCII_CR;
         end
         LF: begin
            in_ready_d = 1'b0;
            wvalid_d   = 1'b1;
            busy_d     = 1'b1;
            wdata_d    = ASCII_LF;
         end
         default: begin
            in_ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset that aborts any emission.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         value_q    <= '0;
         cnt_q      <= CNT_ZERO;
         in_ready_q <= 1'b1;
         wvalid_q   <= 1'b0;
         wdata_q    <= ASCII_NUL;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         value_q    <= value_d;
         cnt_q      <= cnt_d;
         in_ready_q <= in_ready_d;
         wvalid_q   <= wvalid_d;
         wdata_q    <= wdata_d;
         busy_q     <= busy_d;
      end
   end

   assign in_ready = in_ready_q;
   assign wvalid   = wvalid_q;
   assign wdata    = wdata_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_uart_hex_tx.sv
// Self-checking bench for uart_hex_tx: 32-bit CRLF instance and 8-bit bare instance.
module tb_uart_hex_tx;

   logic        clk;
   logic        rst_a, rst_b;
   logic [31:0] in_data_a;
   logic        in_valid_a, in_ready_a, wvalid_a, wready_a, busy_a;
   logic [7:0]  wdata_a;
   logic [7:0]  in_data_b;
   logic        in_valid_b, in_ready_b, wvalid_b, wready_b, busy_b;
   logic [7:0]  wdata_b;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   uart_hex_tx #(.value_width(32), .append_crlf(1'b1)) dut_a (
      .clk(clk), .rst(rst_a), .in_data(in_data_a), .in_valid(in_valid_a),
      .in_ready(in_ready_a), .wdata(wdata_a), .wvalid(wvalid_a),
      .wready(wready_a), .busy(busy_a)
   );

   uart_hex_tx #(.value_width(8), .append_crlf(1'b0)) dut_b (
      .clk(clk), .rst(rst_b), .in_data(in_data_b), .in_valid(in_valid_b),
      .in_ready(in_ready_b), .wdata(wdata_b), .wvalid(wvalid_b),
      .wready(wready_b), .busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the character string a value should print as.
   function automatic void make_chars(input logic [63:0] v, input int ndig, input bit crlf);
      int n;
      exp_q.delete();
      for (int i = ndig - 1; i >= 0; i--) begin
         n = int'(v[4*i +: 4]);
         if (n < 10) exp_q.push_back(8'(48 + n));
         else        exp_q.push_back(8'(55 + n));
      end
      if (crlf) begin
         exp_q.push_back(8'd13);
         exp_q.push_back(8'd10);
      end
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_a(input string tag);
      check({tag, "_in_ready"}, 64'(in_ready_a), 64'd1);
      check({tag, "_wvalid"},   64'(wvalid_a),   64'd0);
      check({tag, "_busy"},     64'(busy_a),     64'd0);
      check({tag, "_wdata"},    64'(wdata_a),    64'd0);
   endtask

   // Called at a negedge with DUT A idle; returns at the negedge of the idle cycle.
   // mode 0: wready=1, 1: toggling 1/0, 2: random. hold keeps in_valid high; pulse
   // injects a foreign value mid-emission.
   task automatic send_a(input logic [31:0] v, input int mode, input bit hold, input bit pulse);
      int cyc;
      bit stall, wr;
      logic [7:0] prev;
      make_chars(64'(v), 8, 1'b1);
      check("a_ready_before", 64'(in_ready_a), 64'd1);
      in_data_a  = v;
      in_valid_a = 1'b1;
      wready_a   = 1'($urandom_range(0, 1));
      cyc = 0; stall = 1'b0; wr = 1'b0; prev = 8'h00;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         cyc++;
         if (cyc > 200) begin
            n_vec++; n_err++;
            $error("FAIL a_timeout: observed %0d chars left expected 0", exp_q.size());
            break;
         end
         in_valid_a = hold;
         if (pulse && cyc == 3) begin
            in_data_a  = 32'h55555555;
            in_valid_a = 1'b1;
         end
         case (mode)
            0:       wr = 1'b1;
            1:       wr = (cyc == 1) ? 1'b1 : !wr;
            default: wr = 1'($urandom_range(0, 1));
         endcase
         wready_a = wr;
         check("a_wvalid", 64'(wvalid_a), 64'd1);
         check("a_busy", 64'(busy_a), 64'd1);
         check("a_in_ready_busy", 64'(in_ready_a), 64'd0);
         if (stall) check("a_stable", 64'(wdata_a), 64'(prev));
         if (wr) begin
            check("a_char", 64'(wdata_a), 64'(exp_q.pop_front()));
            stall = 1'b0;
         end else begin
            stall = 1'b1;
            prev  = wdata_a;
         end
      end
      @(negedge clk);
      in_valid_a = hold;
      wready_a   = 1'($urandom_range(0, 1));
      check_idle_a("a_after");
   endtask

   // DUT B (8-bit, no CRLF) with wready held high: exactly two characters.
   task automatic send_b(input logic [7:0] v);
      make_chars(64'(v), 2, 1'b0);
      check("b_ready_before", 64'(in_ready_b), 64'd1);
      in_data_b  = v;
      in_valid_b = 1'b1;
      wready_b   = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         in_valid_b = 1'b0;
         check("b_wvalid", 64'(wvalid_b), 64'd1);
         check("b_char", 64'(wdata_b), 64'(exp_q.pop_front()));
      end
      @(negedge clk);
      check("b_after_in_ready", 64'(in_ready_b), 64'd1);
      check("b_after_wvalid", 64'(wvalid_b), 64'd0);
      check("b_after_busy", 64'(busy_b), 64'd0);
   endtask

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      in_data_a = 32'hDEAD0000; in_valid_a = 1'b1; wready_a = 1'b1;
      in_data_b = 8'h00; in_valid_b = 1'b0; wready_b = 1'b0;

      // Reset: outputs idle while held, and still idle after release.
      @(negedge clk);
      check_idle_a("rst_during");
      check("b_rst_in_ready", 64'(in_ready_b), 64'd1);
      check("b_rst_wvalid", 64'(wvalid_b), 64'd0);
      @(negedge clk);
      rst_a = 1'b1; rst_b = 1'b1; in_valid_a = 1'b0;
      @(negedge clk);
      check_idle_a("rst_after");

      // Directed values.
      send_a(32'h1234ABCD, 0, 1'b0, 1'b0);
      send_a(32'h00000000, 1, 1'b0, 1'b0);
      send_a(32'hFFFFFFFF, 0, 1'b1, 1'b0);
      send_a(32'h00000001, 0, 1'b0, 1'b0);
      send_a(32'h12345678, 0, 1'b0, 1'b1);

      // Reset lands on the third digit's handshake: emission stops at once.
      make_chars(64'(32'hDEADBEEF), 8, 1'b1);
      in_data_a = 32'hDEADBEEF; in_valid_a = 1'b1; wready_a = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid_a = 1'b0;
         check("rst_mid_char", 64'(wdata_a), 64'(exp_q.pop_front()));
      end
      rst_a = 1'b0;
      @(negedge clk);
      rst_a = 1'b1;
      check_idle_a("rst_mid");
      @(negedge clk);
      check("rst_mid_quiet", 64'(wvalid_a), 64'd0);
      send_a(32'h00000002, 0, 1'b0, 1'b0);

      // Randomized values and backpressure.
      for (int r = 0; r < 8; r++) begin
         send_a($urandom(), 2, 1'b0, 1'b0);
      end

      // Narrow instance without CRLF.
      send_b(8'hF0);
      for (int r = 0; r < 4; r++) begin
         send_b(8'($urandom_range(0, 255)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_hex_tx.md
UART_HEX_TX -- requirements
Module: uart_hex_tx

Interface
REQ-001 SHALL have parameter value_width, default 32, binary value width in bits; legal values are multiples of 4, from 4 to 64.
REQ-002 SHALL have parameter append_crlf, default 1; when 1, each value is followed by CR LF.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 SHALL have port in_data, input, value_width, binary value to print.
REQ-006 SHALL have port in_valid, input, 1, in_data is valid.
REQ-007 SHALL have port in_ready, output, 1, block can accept a value.
REQ-008 SHALL have port wdata, output, 8, ASCII character to the uart tx FIFO.
REQ-009 SHALL have port wvalid, output, 1, wdata is valid.
REQ-010 SHALL have port wready, input, 1, the tx FIFO accepts wdata.
REQ-011 SHALL have port busy, output, 1, a value is being emitted.

Function
REQ-012 SHALL have four states: IDLE, DIGIT, CR, LF.
REQ-013 In IDLE, in_ready SHALL be 1 and wvalid SHALL be 0; in every other state, in_ready SHALL be 0.
REQ-014 On in_valid&&in_ready, SHALL latch in_data, load the digit counter with value_width/4-1, and go to DIGIT.
REQ-015 SHALL assert wvalid in the cycle after acceptance.
REQ-016 DIGIT SHALL emit nibbles MSB-first; nibble 0-9 maps to 0x30-0x39 and 10-15 maps to 0x41-0x46 (uppercase). No prefix and no leading-zero suppression.
REQ-017 Handshake: once asserted, wvalid SHALL stay 1 and wdata SHALL stay stable until wvalid&&wready; the character advances only on that cycle.
REQ-018 With wready held at 1, SHALL emit one character per cycle with no bubbles.
REQ-019 On the handshake of the last digit (counter 0), SHALL go to CR if append_crlf=1, otherwise to IDLE.
REQ-020 CR SHALL emit 0x0D and then go to LF; LF SHALL emit 0x0A and then go to IDLE.
REQ-021 After the final handshake, in_ready SHALL be 1 on the next cycle; the inter-value gap SHALL be exactly one cycle.
REQ-022 in_valid SHALL be ignored while not in IDLE, and the latched value SHALL remain unchanged.
REQ-023 busy SHALL be 1 in DIGIT, CR and LF, and 0 in IDLE.
REQ-024 In IDLE, wdata SHALL be 0x00.
REQ-025 A handshake on wready with wvalid=0 SHALL have no effect.

Reset
REQ-026 When rst=0 at a clock edge, SHALL enter IDLE and clear the latched value and the digit counter.
REQ-027 Outputs during and after reset SHALL be: in_ready=1, wvalid=0, wdata=0x00, busy=0.
REQ-028 Reset mid-emission SHALL abort immediately; no further characters of that value are emitted.

Structure
REQ-029 The shared package SHALL hold the state encoding and the ASCII constants: 0x30, 0x41, 0x0D, 0x0A.
REQ-030 SHALL instantiate one sub-module, nibble_to_ascii: combinational, 4-bit in, 8-bit out, reusable by other ucmd print paths.
REQ-031 The digit counter SHALL be clog2(value_width/4) bits wide; nibbles SHALL be selected by left shift of the latched value.

Verification
REQ-032 in_data=0x1234ABCD, wready=1 -> wdata sequence 0x31,0x32,0x33,0x34,0x41,0x42,0x43,0x44,0x0D,0x0A on 10 consecutive cycles, then in_ready=1.
REQ-033 in_data=0x00000000, wready toggling 1/0 each cycle -> eight 0x30 then 0x0D,0x0A; wdata stable on every wready=0 cycle.
REQ-034 append_crlf=0, value_width=8, in_data=0xF0 -> 0x46,0x30 only; in_ready=1 on the next cycle.
REQ-035 Back-to-back values 0xFFFFFFFF then 0x00000001 with in_valid held -> exactly one idle cycle between the two 0x0A characters' next value start; second value latched correctly.
REQ-036 rst=0 after the third digit of 0xDEADBEEF -> wvalid=0, busy=0 on the next cycle; new value 0x00000002 emits correctly.
REQ-037 in_valid pulsed with 0x55555555 during emission of 0x12345678 -> output is unaffected and 0x55555555 is not printed.
